// File: rtl/output_pair_pkg.sv
// Shared definitions for the output-pair serializer.
//   PAIR_W      width of one registered output pair (pin1, pin2)
//   GAP_W       width of the inter-frame gap counter (IDLE_GAP is 0..15)
//   ser_state_t serializer FSM states
package output_pair_pkg;

  localparam int PAIR_W = 2;
  localparam int GAP_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    BIT0,
    BIT1,
    GAP
  } ser_state_t;

endpackage

// File: rtl/output_pair_serializer_fifo.sv
// pair_fifo: DEPTH x PAIR_W synchronous FIFO with occupancy count.
// Ports:
//   src_clk  sole clock, posedge
//   rst      synchronous active-high reset (pointers and count only)
//   push     write wr_data this edge (ignored while full)
//   wr_data  pair to store
//   pop      advance the read pointer this edge (ignored while empty)
//   rd_data  head of the FIFO (valid while !empty)
//   count    occupancy 0..DEPTH
//   full     count == DEPTH
//   empty    count == 0
module pair_fifo
  import output_pair_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              src_clk,
  input  logic              rst,
  input  logic              push,
  input  logic [PAIR_W-1:0] wr_data,
  input  logic              pop,
  output logic [PAIR_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PAIR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: the storage array has no reset; an entry is only read after it was
  // written, so resetting pointers and count is enough and keeps it a RAM.
  always_ff @(posedge src_clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge src_clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/output_pair_serializer.sv
// output_pair_serializer: buffers 2-bit output pairs and sends each one as a
// two-bit frame on a single registered output.
// Ports:
//   src_clk     sole clock, posedge
//   rst         synchronous active-high reset
//   in_valid    upstream pair valid
//   in_pair     [0]=pin1 bit, [1]=pin2 bit
//   in_ready    FIFO can accept (count != DEPTH)
//   out_en      downstream enable; 0 freezes the serializer
//   ser_out     serialized data bit, registered
//   ser_frame   high while ser_out carries a frame bit, registered
//   ser_last    high on the second bit of a frame, registered
//   fifo_count  FIFO occupancy 0..DEPTH
//   overflow    sticky: in_valid seen while full
module output_pair_serializer
  import output_pair_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int IDLE_GAP = 1
) (
  input  logic                     src_clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [PAIR_W-1:0]        in_pair,
  output logic                     in_ready,
  input  logic                     out_en,
  output logic                     ser_out,
  output logic                     ser_frame,
  output logic                     ser_last,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

  ser_state_t        state_q, state_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [PAIR_W-1:0] held_q, held_d;
  logic              out_q, out_d;
  logic              frame_q, frame_d;
  logic              last_q, last_d;
  logic              start_frame;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [PAIR_W-1:0] head;

  pair_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .src_clk (src_clk),
    .rst     (rst),
    .push    (in_valid && in_ready),
    .wr_data (in_pair),
    .pop     (pop),
    .rd_data (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // A pop in the same cycle never frees a slot for a push while full.
  assign in_ready = !fifo_full;

  // Next-state and next-output logic.
  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    held_d      = held_q;
    out_d       = out_q;
    frame_d     = frame_q;
    last_d      = last_q;
    start_frame = 1'b0;
    pop         = 1'b0;

    if (out_en) begin
      unique case (state_q)
        IDLE: start_frame = 1'b1;
        BIT0: begin
          out_d   = held_q[1];
          frame_d = 1'b1;
          last_d  = 1'b1;
          state_d = BIT1;
        end
        BIT1: begin
          if (IDLE_GAP == 0) begin
            start_frame = 1'b1;
          end else begin
            out_d   = 1'b0;
            frame_d = 1'b0;
            last_d  = 1'b0;
            gap_d   = GAP_LOAD;
            state_d = GAP;
          end
        end
        GAP: begin
          // The final gap cycle doubles as the IDLE decision so the frame
          // period is exactly 2 + IDLE_GAP cycles while data keeps coming.
          if (gap_q == '0) begin
            start_frame = 1'b1;
          end else begin
            out_d   = 1'b0;
            frame_d = 1'b0;
            last_d  = 1'b0;
            gap_d   = gap_q - 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase

      if (start_frame) begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          held_d  = head;
          out_d   = head[0];
          frame_d = 1'b1;
          last_d  = 1'b0;
          state_d = BIT0;
        end else begin
          out_d   = 1'b0;
          frame_d = 1'b0;
          last_d  = 1'b0;
          state_d = IDLE;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge src_clk) begin
    if (rst) begin
      state_q <= IDLE;
      gap_q   <= '0;
      held_q  <= '0;
      out_q   <= 1'b0;
      frame_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      held_q  <= held_d;
      out_q   <= out_d;
      frame_q <= frame_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge src_clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (in_valid && !in_ready) begin
      overflow <= 1'b1;
    end
  end

  assign ser_out   = out_q;
  assign ser_frame = frame_q;
  assign ser_last  = last_q;

endmodule
